video_timing: RTL and testbench

//  Generates 640x480@60 VGA raster timing from a 25.175 MHz pixel clock and maps it to the 256x240

---
 rtl/video_timing.sv | 160 ++++++++++++++++
 tb/tb_video_timing.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// rtl/video_timing.sv - 640x480@60 VGA raster timing with a 2x-scaled 256x240 game window
//
// Purpose:
//   Free-running horizontal/vertical raster counters clocked by the pixel clock.
//   Sync pulses, game-window coordinates, blanking flags and the vblank interrupt
//   are all decoded from the counters and registered, so every output at cycle n
//   describes the raster position (h_count, v_count) held during cycle n-1.
//   That keeps the syncs and the coordinates mutually aligned.
//
// Optional feature:
//   `SCANLINE_IRQ_EN - adds scanline_cmp_i / scanline_irq_o and the row comparator.
//
// Ports:
//   gpu_clk            in   1  pixel clock, all logic on posedge
//   rst_n              in   1  synchronous active-low reset
//   hsync_o            out  1  horizontal sync, active low
//   vsync_o            out  1  vertical sync, active low
//   display_x_o        out  8  game-window column 0..255 (0 outside the window)
//   display_y_o        out  8  game-window row 0..239 (0 in vertical blanking)
//   display_active_o   out  1  pixel lies inside the game window
//   vblank_o           out  1  raster in vertical blanking
//   vblank_start_o     out  1  one-cycle pulse on the first pixel of line V_VISIBLE
//   irq_o              out  1  vblank interrupt, level, sticky until acknowledged
//   irq_ack_i          in   1  CPU acknowledge, clears irq_o and scanline_irq_o
//   scanline_cmp_i     in   8  compare row for the scanline interrupt (optional)
//   scanline_irq_o     out  1  scanline interrupt, sticky (optional)

module video_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int H_OFFSET  = 64
) (
    input  logic       gpu_clk,
    input  logic       rst_n,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [7:0] display_x_o,
    output logic [7:0] display_y_o,
    output logic       display_active_o,
    output logic       vblank_o,
    output logic       vblank_start_o,
    output logic       irq_o,
    input  logic       irq_ack_i
`ifdef SCANLINE_IRQ_EN
    ,
    input  logic [7:0] scanline_cmp_i,
    output logic       scanline_irq_o
`endif
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    // 256 game pixels, each doubled horizontally
    localparam int WIN_WIDTH    = 512;
    localparam int WIN_END      = H_OFFSET + WIN_WIDTH;

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       h_last;
    logic       v_last;

    // Decoded values for the current raster position; registered below.
    logic       hsync_n;
    logic       vsync_n;
    logic       v_visible_n;
    logic       active_n;
    logic [7:0] x_n;
    logic [7:0] y_n;
    logic       vblank_start_n;

    assign h_last = (h_count == 10'(H_TOTAL - 1));
    assign v_last = (v_count == 10'(V_TOTAL - 1));

    always_comb begin
        hsync_n        = !((h_count >= 10'(H_SYNC_START)) && (h_count < 10'(H_SYNC_END)));
        vsync_n        = !((v_count >= 10'(V_SYNC_START)) && (v_count < 10'(V_SYNC_END)));
        v_visible_n    = (v_count < 10'(V_VISIBLE));
        active_n       = v_visible_n &&
                         (h_count >= 10'(H_OFFSET)) && (h_count < 10'(WIN_END));
        // Each game pixel spans two raster pixels/lines, hence the halving.
        x_n            = active_n ? 8'((h_count - 10'(H_OFFSET)) >> 1) : 8'd0;
        y_n            = v_visible_n ? 8'(v_count >> 1) : 8'd0;
        vblank_start_n = (h_count == 10'd0) && (v_count == 10'(V_VISIBLE));
    end

    always_ff @(posedge gpu_clk) begin
        if (!rst_n) begin
            h_count <= 10'd0;
            v_count <= 10'd0;
        end else if (h_last) begin
            h_count <= 10'd0;
            v_count <= v_last ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    always_ff @(posedge gpu_clk) begin
        if (!rst_n) begin
            hsync_o          <= 1'b1;
            vsync_o          <= 1'b1;
            display_x_o      <= 8'd0;
            display_y_o      <= 8'd0;
            display_active_o <= 1'b0;
            vblank_o         <= 1'b0;
            vblank_start_o   <= 1'b0;
        end else begin
            hsync_o          <= hsync_n;
            vsync_o          <= vsync_n;
            display_x_o      <= x_n;
            display_y_o      <= y_n;
            display_active_o <= active_n;
            vblank_o         <= !v_visible_n;
            vblank_start_o   <= vblank_start_n;
        end
    end

    // Sticky interrupt: a new vblank event in the same cycle as an ack wins,
    // so the CPU never loses a frame it has not yet seen.
    always_ff @(posedge gpu_clk) begin
        if (!rst_n) begin
            irq_o <= 1'b0;
        end else if (vblank_start_n) begin
            irq_o <= 1'b1;
        end else if (irq_ack_i) begin
            irq_o <= 1'b0;
        end
    end

`ifdef SCANLINE_IRQ_EN
    // Game row r occupies raster lines 2r and 2r+1; fire on the first of them.
    // Rows beyond the visible game window never match.
    logic scan_hit;

    assign scan_hit = (h_count == 10'd0) &&
                      (scanline_cmp_i < 8'(V_VISIBLE / 2)) &&
                      (v_count == {1'b0, scanline_cmp_i, 1'b0});

    always_ff @(posedge gpu_clk) begin
        if (!rst_n) begin
            scanline_irq_o <= 1'b0;
        end else if (scan_hit) begin
            scanline_irq_o <= 1'b1;
        end else if (irq_ack_i) begin
            scanline_irq_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - scoreboard bench for video_timing with a raster-position reference model

module tb_video_timing;

    // Horizontal timing at full size; vertical timing shortened to keep frames short.
    localparam int HV = 640, HF = 16, HS = 96, HB = 48, HO = 64;
    localparam int VV = 12, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       gpu_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       irq_ack_i = 1'b0;
    logic       hsync_o, vsync_o, display_active_o, vblank_o, vblank_start_o, irq_o;
    logic [7:0] display_x_o, display_y_o;
`ifdef SCANLINE_IRQ_EN
    logic [7:0] scanline_cmp_i = 8'd3;
    logic       scanline_irq_o;
`endif

    video_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_OFFSET(HO)
    ) dut (
        .gpu_clk(gpu_clk),
        .rst_n(rst_n),
        .hsync_o(hsync_o),
        .vsync_o(vsync_o),
        .display_x_o(display_x_o),
        .display_y_o(display_y_o),
        .display_active_o(display_active_o),
        .vblank_o(vblank_o),
        .vblank_start_o(vblank_start_o),
        .irq_o(irq_o),
        .irq_ack_i(irq_ack_i)
`ifdef SCANLINE_IRQ_EN
        ,
        .scanline_cmp_i(scanline_cmp_i),
        .scanline_irq_o(scanline_irq_o)
`endif
    );

    always #5 gpu_clk = ~gpu_clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [7:0] x;
        logic [7:0] y;
        logic       act;
        logic       vb;
        logic       vbs;
        logic       irq;
        logic       sirq;
    } out_t;

    out_t exp_q[$];
    int   pos;          // raster position (linear pixel index) the DUT counters hold now
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   rand_ack = 1'b0;
    bit   done = 1'b0;

    task automatic summary_and_finish();
        if (!done) begin
            done = 1'b1;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: derives every output from the linear raster position.
    initial begin : model
        out_t e;
        int   h, v;
        bit   m_irq, m_sirq;
        pos = 0;
        m_irq = 1'b0;
        m_sirq = 1'b0;
        forever begin
            @(posedge gpu_clk);
            e = '0;
            if (!rst_n) begin
                pos = 0;
                m_irq = 1'b0;
                m_sirq = 1'b0;
                e.hs = 1'b1;
                e.vs = 1'b1;
            end else begin
                h = pos % HT;
                v = pos / HT;
                e.hs  = !(h >= HV + HF && h < HV + HF + HS);
                e.vs  = !(v >= VV + VF && v < VV + VF + VS);
                e.act = (h >= HO) && (h < HO + 512) && (v < VV);
                e.x   = e.act ? 8'((h - HO) / 2) : 8'd0;
                e.y   = (v < VV) ? 8'(v / 2) : 8'd0;
                e.vb  = (v >= VV);
                e.vbs = (h == 0) && (v == VV);
                if (e.vbs) m_irq = 1'b1;
                else if (irq_ack_i) m_irq = 1'b0;
                e.irq = m_irq;
`ifdef SCANLINE_IRQ_EN
                if (h == 0 && int'(scanline_cmp_i) < VV / 2 && v == 2 * int'(scanline_cmp_i))
                    m_sirq = 1'b1;
                else if (irq_ack_i)
                    m_sirq = 1'b0;
                e.sirq = m_sirq;
`endif
                pos = (pos + 1) % FRAME;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: pops one expectation per output cycle and compares on the falling edge.
    initial begin : monitor
        out_t e, a;
        forever begin
            @(negedge gpu_clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '0;
                a.hs = hsync_o;   a.vs = vsync_o;
                a.x = display_x_o; a.y = display_y_o;
                a.act = display_active_o; a.vb = vblank_o;
                a.vbs = vblank_start_o;   a.irq = irq_o;
`ifdef SCANLINE_IRQ_EN
                a.sirq = scanline_irq_o;
`endif
                n_cmp++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL raster t=%0t: got hs=%b vs=%b x=%0d y=%0d act=%b vb=%b vbs=%b irq=%b sirq=%b expected hs=%b vs=%b x=%0d y=%0d act=%b vb=%b vbs=%b irq=%b sirq=%b",
                             $time, a.hs, a.vs, a.x, a.y, a.act, a.vb, a.vbs, a.irq, a.sirq,
                             e.hs, e.vs, e.x, e.y, e.act, e.vb, e.vbs, e.irq, e.sirq);
                    if (n_fail >= 40) summary_and_finish();
                end
            end
        end
    end

    initial begin : watchdog
        #(150000 * 10);
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        summary_and_finish();
    end

    // One clock step; inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge gpu_clk);
        #1;
        if (rand_ack) begin
            irq_ack_i = ($urandom_range(0, 149) == 0);
`ifdef SCANLINE_IRQ_EN
            if ($urandom_range(0, 499) == 0) scanline_cmp_i = 8'($urandom_range(0, 9));
`endif
        end
    endtask

    task automatic wait_pos(input int p);
        int guard = 0;
        while (pos != p && guard < 2 * FRAME) begin
            cyc();
            guard++;
        end
        if (guard >= 2 * FRAME) check("wait_pos_timeout", pos, p);
    endtask

    // Returns on the falling edge where outputs describe raster position p.
    task automatic observe(input int p);
        wait_pos(p);
        cyc();
        @(negedge gpu_clk);
    endtask

    initial begin : stimulus
        int n_h, n_v, n_vbs;

        // Reset held, then released: first output describes (0,0).
        repeat (5) cyc();
        @(negedge gpu_clk);
        check("reset_hsync", hsync_o, 1);
        check("reset_vsync", vsync_o, 1);
        check("reset_active", display_active_o, 0);
        check("reset_irq", irq_o, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        @(negedge gpu_clk);
        check("first_x", display_x_o, 0);
        check("first_y", display_y_o, 0);
        check("first_active", display_active_o, 0);

        // Sync pulse widths over whole periods (window alignment is irrelevant).
        rand_ack = 1'b1;
        n_h = 0;
        repeat (HT) begin cyc(); @(negedge gpu_clk); if (!hsync_o) n_h++; end
        check("hsync_low_per_line", n_h, HS);
        n_h = 0; n_v = 0; n_vbs = 0;
        repeat (FRAME) begin
            cyc(); @(negedge gpu_clk);
            if (!hsync_o) n_h++;
            if (!vsync_o) n_v++;
            if (vblank_start_o) n_vbs++;
        end
        check("hsync_low_per_frame", n_h, HS * VT);
        check("vsync_low_per_frame", n_v, VS * HT);
        check("vblank_start_per_frame", n_vbs, 1);

        // Window edges on raster line 10.
        observe(10 * HT + HO);
        check("win_left_active", display_active_o, 1);
        check("win_left_x", display_x_o, 0);
        check("line10_y", display_y_o, 5);
        cyc(); @(negedge gpu_clk);
        check("win_left1_x", display_x_o, 0);
        observe(10 * HT + HO + 511);
        check("win_right_active", display_active_o, 1);
        check("win_right_x", display_x_o, 255);
        cyc(); @(negedge gpu_clk);
        check("win_past_active", display_active_o, 0);
        check("win_past_x", display_x_o, 0);

        // Vblank interrupt set, ack, and set-wins-over-ack.
        rand_ack = 1'b0;
        irq_ack_i = 1'b0;
        wait_pos(VV * HT - 10);
        irq_ack_i = 1'b1; cyc(); irq_ack_i = 1'b0;
        @(negedge gpu_clk);
        check("irq_cleared_before", irq_o, 0);
        observe(VV * HT);
        check("irq_set", irq_o, 1);
        check("vblank_start_pulse", vblank_start_o, 1);
        check("vblank_flag", vblank_o, 1);
        wait_pos((VV + 1) * HT);
        irq_ack_i = 1'b1; cyc(); irq_ack_i = 1'b0;
        @(negedge gpu_clk);
        check("irq_ack_clears", irq_o, 0);
        wait_pos(VV * HT);
        irq_ack_i = 1'b1; cyc(); irq_ack_i = 1'b0;
        @(negedge gpu_clk);
        check("irq_set_wins", irq_o, 1);
        cyc(); @(negedge gpu_clk);
        check("irq_sticky", irq_o, 1);
        check("vblank_start_one_cycle", vblank_start_o, 0);

`ifdef SCANLINE_IRQ_EN
        scanline_cmp_i = 8'd3;
        wait_pos(HT + 5);
        irq_ack_i = 1'b1; cyc(); irq_ack_i = 1'b0;
        @(negedge gpu_clk);
        check("scan_cleared", scanline_irq_o, 0);
        observe(6 * HT);
        check("scan_set", scanline_irq_o, 1);
        scanline_cmp_i = 8'(VV / 2);
        irq_ack_i = 1'b1; cyc(); irq_ack_i = 1'b0;
        n_v = 0;
        repeat (FRAME + 10) begin cyc(); @(negedge gpu_clk); if (scanline_irq_o) n_v++; end
        check("scan_out_of_range", n_v, 0);
        rand_ack = 1'b1;
`endif

        // Mid-line reset: counters restart, hsync first falls 656 cycles after (0,0).
        rand_ack = 1'b1;
        wait_pos(5 * HT + 300);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        cyc(); @(negedge gpu_clk);
        check("midreset_y", display_y_o, 0);
        n_h = 0;
        while (hsync_o === 1'b1 && n_h < 2000) begin
            cyc(); @(negedge gpu_clk);
            n_h++;
        end
        check("midreset_hsync_delay", n_h, HV + HF);

        // Random traffic across the vblank region.
        wait_pos((VV + 2) * HT);
        rand_ack = 1'b0;
        irq_ack_i = 1'b0;
        repeat (3) cyc();
        @(negedge gpu_clk);
        @(negedge gpu_clk);
        summary_and_finish();
    end

endmodule
